// File: rtl/uart_rx_ctrl.sv
// Sequencer and receive FIFO for the oversampling UART receiver: generates the
// oversample tick, holds the receiver in reset while disabled, buffers bytes FWFT.
module uart_rx_ctrl #(
  parameter int unsigned    DATA    = 8,
  parameter int unsigned    DEPTH   = 16,
  parameter int unsigned    CLK_DIV = 27,
  parameter logic [DATA-1:0] EOL    = DATA'(8'h0D),
  localparam int unsigned   CW      = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic [DATA-1:0] i_rx_data,
  input  logic            i_rx_ready,
  output logic            o_rx_tick,
  output logic            o_rx_rst,
  output logic [DATA-1:0] o_data,
  output logic            o_valid,
  input  logic            i_pop,
  output logic [CW-1:0]   o_count,
  output logic [CW-1:0]   o_lines,
  output logic            o_line_ready,
  output logic            o_overrun,
  input  logic            i_clr_overrun
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_OFF, S_FLUSH, S_RUN} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   cnt, cnt_d;
  logic            tick_d, rx_rst_d, flush;
  logic            ready_q, rise, pop_ok, push_ok, full;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_d, lines_d;
  logic            lines_inc, lines_dec;
  logic [DATA-1:0] mem [DEPTH];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_OFF;
    else          state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_OFF:   if (i_enable) state_d = S_FLUSH;
      S_FLUSH: state_d = S_RUN;
      S_RUN:   if (!i_enable) state_d = S_OFF;
      default: state_d = S_OFF;
    endcase
  end

  // Output decode: next values of the registered receiver controls
  always_comb begin
    cnt_d    = '0;
    tick_d   = 1'b0;
    rx_rst_d = (state_d != S_RUN);
    flush    = (state == S_FLUSH);
    if (state == S_RUN && state_d == S_RUN)
      cnt_d = (cnt == TW'(CLK_DIV - 1)) ? '0 : cnt + TW'(1);
    if (state_d == S_RUN)
      tick_d = (cnt_d == TW'(CLK_DIV - 1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      o_rx_tick <= 1'b0;
      o_rx_rst  <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      o_rx_tick <= tick_d;
      o_rx_rst  <= rx_rst_d;
      ready_q   <= i_rx_ready;
    end
  end

  // FIFO control; when full, a same-cycle pop frees the slot being written
  always_comb begin
    rise      = (state == S_RUN) && i_rx_ready && !ready_q;
    pop_ok    = i_pop && o_valid;
    full      = (o_count == CW'(DEPTH));
    push_ok   = rise && (!full || pop_ok);
    lines_inc = push_ok && (i_rx_data == EOL);
    lines_dec = pop_ok && (o_data == EOL);
    count_d   = o_count;
    lines_d   = o_lines;
    if (push_ok && !pop_ok) count_d = o_count + CW'(1);
    if (!push_ok && pop_ok) count_d = o_count - CW'(1);
    if (lines_inc && !lines_dec) lines_d = o_lines + CW'(1);
    if (!lines_inc && lines_dec) lines_d = o_lines - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      o_count   <= '0;
      o_lines   <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      o_count   <= '0;
      o_lines   <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      o_count <= count_d;
      o_lines <= lines_d;
      o_valid <= (count_d != '0);
      if (rise && !push_ok)  o_overrun <= 1'b1;
      else if (i_clr_overrun) o_overrun <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= i_rx_data;
    end
  end

  assign o_data       = mem[rd_ptr];
  assign o_line_ready = (o_lines != '0);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: enable/tick timing, capture, lines, overrun, wrap, disable, reset.
module tb_uart_rx_ctrl;

  localparam int unsigned DATA  = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DIV   = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n, enable, rx_ready, pop, clr_overrun;
  logic [DATA-1:0] rx_data;
  logic            rx_tick, rx_rst, valid, line_ready, overrun;
  logic [DATA-1:0] data;
  logic [CW-1:0]   count, lines;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA(DATA), .DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_rx_data(rx_data), .i_rx_ready(rx_ready),
    .o_rx_tick(rx_tick), .o_rx_rst(rx_rst),
    .o_data(data), .o_valid(valid), .i_pop(pop),
    .o_count(count), .o_lines(lines), .o_line_ready(line_ready),
    .o_overrun(overrun), .i_clr_overrun(clr_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
  endtask

  task automatic pop_byte();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rx_rst"}, rx_rst, 1);
    check({tag, "_tick"}, rx_tick, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_lines"}, lines, 0);
    check({tag, "_line_ready"}, line_ready, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_data"}, data, 0);
  endtask

  int rd;

  initial begin
    rst_n = 1'b0; enable = 1'b0; rx_ready = 1'b0; pop = 1'b0;
    clr_overrun = 1'b0; rx_data = '0;
    step(); step();
    check_idle("reset");
    rst_n = 1'b1;
    step(); step();
    check("off_rx_rst", rx_rst, 1);

    // Enable: flush for one cycle, then run with a tick every DIV cycles
    enable = 1'b1;
    step();
    check("flush_rx_rst", rx_rst, 1);
    check("flush_tick", rx_tick, 0);
    step();
    check("run_rx_rst", rx_rst, 0);
    check("run_tick0", rx_tick, 0);
    check("run_count", count, 0);
    check("run_overrun", overrun, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("tick_k%0d", k), rx_tick, ((k % 4) == 3) ? 1 : 0);
    end

    // Single byte with a long ready level
    rx_data = 8'h41; rx_ready = 1'b1;
    repeat (10) step();
    rx_ready = 1'b0;
    step();
    check("single_count", count, 1);
    check("single_data", data, 8'h41);
    check("single_valid", valid, 1);
    pop_byte();
    check("single_pop_count", count, 0);
    check("single_pop_valid", valid, 0);

    // Line detect
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h0D);
    check("line_count", count, 3);
    check("line_lines", lines, 1);
    check("line_ready", line_ready, 1);
    check("line_d0", data, 8'h31); pop_byte();
    check("line_lines_a", lines, 1);
    check("line_d1", data, 8'h32); pop_byte();
    check("line_d2", data, 8'h0D); pop_byte();
    check("line_lines_end", lines, 0);
    check("line_ready_end", line_ready, 0);

    // Fill, overrun, clear collision, push with pop while full
    for (int i = 0; i < 16; i++) push_byte(8'(8'h50 + i));
    check("full_count", count, 16);
    check("full_overrun0", overrun, 0);
    push_byte(8'h99);
    check("full_count17", count, 16);
    check("full_overrun1", overrun, 1);
    rx_data = 8'h98; rx_ready = 1'b1; clr_overrun = 1'b1;
    step();
    rx_ready = 1'b0; clr_overrun = 1'b0;
    step();
    check("clr_set_wins", overrun, 1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("clr_overrun", overrun, 0);
    check("full_head", data, 8'h50);
    rx_data = 8'hA0; rx_ready = 1'b1; pop = 1'b1;
    step();
    rx_ready = 1'b0; pop = 1'b0;
    step();
    check("full_pushpop_count", count, 16);
    check("full_pushpop_overrun", overrun, 0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_%0d", i), data, 8'(8'h50 + i));
      pop_byte();
    end
    check("drain_last", data, 8'hA0);
    pop_byte();
    check("drain_count", count, 0);

    // Wrap-around with interleaved push/pop
    rd = 0;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(i));
      if (i >= 2) begin
        check($sformatf("wrap_%0d", rd), data, rd);
        pop_byte();
        rd++;
      end
    end
    while (rd < 40 && valid) begin
      check($sformatf("wrap_%0d", rd), data, rd);
      pop_byte();
      rd++;
    end
    check("wrap_all_read", rd, 40);
    check("wrap_count", count, 0);
    check("wrap_lines", lines, 0);

    // Disable: FIFO retained, receiver held, no capture
    push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
    enable = 1'b0;
    step();
    check("off_rx_rst2", rx_rst, 1);
    check("off_count", count, 3);
    push_byte(8'h70);
    repeat (4) step();
    check("off_tick", rx_tick, 0);
    check("off_no_capture", count, 3);
    check("off_head", data, 8'h61);
    pop_byte();
    check("off_pop_count", count, 2);
    check("off_pop_head", data, 8'h62);

    // Re-enable with ready already high: flush, and no push
    rx_ready = 1'b1;
    enable = 1'b1;
    repeat (5) step();
    check("reen_rx_rst", rx_rst, 0);
    check("reen_count", count, 0);
    check("reen_valid", valid, 0);
    check("reen_overrun", overrun, 0);
    rx_ready = 1'b0;
    step();

    // Asynchronous reset mid-capture
    push_byte(8'h0D);
    check("pre_rst_lines", lines, 1);
    rx_data = 8'h55; rx_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    rx_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
